// File: rtl/ov5642_pixel_packer.sv
// ov5642_pixel_packer
// Packs the OV5642 capture stage's byte-wide write stream into 32-bit words.
// Each word is queued in a show-ahead FIFO together with its word address and a
// frame-start marker, then handed to the DMA stage over a valid/ready stream.
//
// Output handshake: m_tvalid is high whenever the FIFO holds a word, and the
// head word (m_tdata/m_taddr/m_tuser) is held stable until it is taken. A word
// transfers on every pclk edge where m_tvalid && m_tready. m_tvalid never waits
// for m_tready.
module ov5642_pixel_packer #(
  parameter int ADDR_W     = 17,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          pclk,
  input  logic                          reset_n,
  input  logic [ADDR_W-1:0]             address,
  input  logic [7:0]                    pix_data,
  input  logic                          write_enable,
  output logic [31:0]                   m_tdata,
  output logic [ADDR_W-3:0]             m_taddr,
  output logic                          m_tuser,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic                          overflow,
  output logic                          misalign,
  input  logic                          clear_flags
);

  localparam int WA_W  = ADDR_W - 2;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Word assembly state
  logic [7:0]      lane0_q, lane1_q, lane2_q;
  logic            pend_q;
  logic [1:0]      exp_lane_q;
  logic [WA_W-1:0] pend_addr_q;

  // Incoming byte decode
  logic [1:0]      byte_lane;
  logic [WA_W-1:0] byte_waddr;
  logic            in_seq;
  logic            mis_ev;
  logic            word_done;
  logic [7:0]      base_l0, base_l1, base_l2;
  logic [7:0]      nxt_l0, nxt_l1, nxt_l2;
  logic [31:0]     word_data;

  // FIFO state
  logic [31:0]      mem_data [FIFO_DEPTH];
  logic [WA_W-1:0]  mem_addr [FIFO_DEPTH];
  logic             mem_user [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;

  // Sticky flags
  logic overflow_q, misalign_q;

  assign byte_lane  = address[1:0];
  assign byte_waddr = address[ADDR_W-1:2];

  // Continuity check and next lane contents; a broken sequence wipes the partial word first
  always_comb begin
    in_seq  = 1'b0;
    mis_ev  = 1'b0;
    base_l0 = lane0_q;
    base_l1 = lane1_q;
    base_l2 = lane2_q;
    if (pend_q) begin
      in_seq = (byte_lane == exp_lane_q) && (byte_waddr == pend_addr_q);
    end else begin
      in_seq = (byte_lane == 2'd0);
    end
    mis_ev = write_enable && pend_q && !in_seq;
    if (mis_ev) begin
      base_l0 = 8'd0;
      base_l1 = 8'd0;
      base_l2 = 8'd0;
    end
    nxt_l0 = base_l0;
    nxt_l1 = base_l1;
    nxt_l2 = base_l2;
    case (byte_lane)
      2'd0:    nxt_l0 = pix_data;
      2'd1:    nxt_l1 = pix_data;
      2'd2:    nxt_l2 = pix_data;
      default: ;
    endcase
    word_done = write_enable && (byte_lane == 2'd3);
    word_data = {pix_data, base_l2, base_l1, base_l0};
  end

  // Lane registers and pending-word tracking
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      lane0_q     <= 8'd0;
      lane1_q     <= 8'd0;
      lane2_q     <= 8'd0;
      pend_q      <= 1'b0;
      exp_lane_q  <= 2'd0;
      pend_addr_q <= '0;
    end else if (write_enable) begin
      if (word_done) begin
        lane0_q    <= 8'd0;
        lane1_q    <= 8'd0;
        lane2_q    <= 8'd0;
        pend_q     <= 1'b0;
        exp_lane_q <= 2'd0;
      end else begin
        lane0_q     <= nxt_l0;
        lane1_q     <= nxt_l1;
        lane2_q     <= nxt_l2;
        pend_q      <= 1'b1;
        exp_lane_q  <= byte_lane + 2'd1;
        pend_addr_q <= byte_waddr;
      end
    end
  end

  assign full = (count == CNT_W'(FIFO_DEPTH));
  assign pop  = m_tvalid && m_tready;
  assign push = word_done && (!full || pop);
  assign drop = word_done && !push;

  // FIFO storage; contents are only visible while the slot is occupied, so no reset
  always_ff @(posedge pclk) begin
    if (push) begin
      mem_data[wr_ptr] <= word_data;
      mem_addr[wr_ptr] <= byte_waddr;
      mem_user[wr_ptr] <= (byte_waddr == '0);
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Sticky error flags; a new event on the clearing edge keeps the flag set
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      if (drop)             overflow_q <= 1'b1;
      else if (clear_flags) overflow_q <= 1'b0;
      if (mis_ev)           misalign_q <= 1'b1;
      else if (clear_flags) misalign_q <= 1'b0;
    end
  end

  // Head word is gated by occupancy so the stream reads all-zero when empty or in reset
  always_comb begin
    m_tvalid   = (count != '0);
    m_tdata    = m_tvalid ? mem_data[rd_ptr] : 32'd0;
    m_taddr    = m_tvalid ? mem_addr[rd_ptr] : '0;
    m_tuser    = m_tvalid ? mem_user[rd_ptr] : 1'b0;
    fill_level = count;
    overflow   = overflow_q;
    misalign   = misalign_q;
  end

endmodule
